// File: rtl/uc_arbiter_pkg.sv
// Shared types and constants for the unit-clause arbiter slice.
//   literal_t       : default-width literal (MSB = polarity, rest = variable index)
//   uc_arb_state_e  : broadcast FSM states
//   VAR_IDX_W       : variable-index width for the default literal width
//   NULL_VAR        : variable index marking a null literal
package c_arbiter_pkg;

    localparam int unsigned DEF_VARIABLE_LENGTH = 11;
    localparam int unsigned VAR_IDX_W           = DEF_VARIABLE_LENGTH - 1;
    localparam logic [VAR_IDX_W-1:0] NULL_VAR   = '0;

    typedef logic [DEF_VARIABLE_LENGTH-1:0] literal_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BCAST    = 2'd1,
        WAIT     = 2'd2,
        CONFLICT = 2'd3
    } uc_arb_state_e;

endpackage

// File: rtl/uc_arbiter_if.sv
// Engine / distribution-unit bus of the unit-clause arbiter.
//   uc_valid_in, uc_in, conflict_in : per-engine requests, literals, conflicts
//   round_done_in, clear_in         : round completion and synchronous flush
//   uc_grant_out                    : one-hot accept (combinational)
//   chosen_uc_out/_valid_out        : broadcast literal and one-cycle strobe
//   conflict_out, idle_out          : sticky conflict, idle status
//   fifo_count_out                  : FIFO occupancy
// Modports: slave = arbiter side, master = engines / distribution side.
interface uc_arbiter_if
    import c_arbiter_pkg::*;
#(
    parameter int NUM_ENGINE      = 4,
    parameter int VARIABLE_LENGTH = DEF_VARIABLE_LENGTH,
    parameter int UC_DEPTH        = 16
);
    localparam int CNT_W = $clog2(UC_DEPTH + 1);

    logic [NUM_ENGINE-1:0]                      uc_valid_in;
    logic [NUM_ENGINE-1:0][VARIABLE_LENGTH-1:0] uc_in;
    logic [NUM_ENGINE-1:0]                      conflict_in;
    logic                                       round_done_in;
    logic                                       clear_in;
    logic [NUM_ENGINE-1:0]                      uc_grant_out;
    logic [VARIABLE_LENGTH-1:0]                 chosen_uc_out;
    logic                                       chosen_uc_valid_out;
    logic                                       conflict_out;
    logic                                       idle_out;
    logic [CNT_W-1:0]                           fifo_count_out;

    modport slave (
        input  uc_valid_in, uc_in, conflict_in, round_done_in, clear_in,
        output uc_grant_out, chosen_uc_out, chosen_uc_valid_out,
               conflict_out, idle_out, fifo_count_out
    );

    modport master (
        output uc_valid_in, uc_in, conflict_in, round_done_in, clear_in,
        input  uc_grant_out, chosen_uc_out, chosen_uc_valid_out,
               conflict_out, idle_out, fifo_count_out
    );

endinterface

// File: rtl/uc_fifo.sv
// Synchronous FIFO with occupancy count and synchronous flush.
//   clock, reset : rising-edge clock, asynchronous active-low reset
//   flush        : empties the FIFO (wins over push/pop)
//   push, din    : write request and data (ignored when full)
//   pop, dout    : read request and head-of-queue data (ignored when empty)
//   full, empty, count : status
// DEPTH must be a power of two so the pointers wrap naturally.
module uc_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 11
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               din,
    output logic [WIDTH-1:0]               dout,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uc_arbiter.sv
// Unit-clause arbiter: round-robin collection of unit clauses from
// NUM_ENGINE BCP engines into a FIFO, one broadcast per propagation round,
// and a sticky conflict halt that only clear_in releases.
//   clock, reset : rising-edge clock, asynchronous active-low reset
//   bus          : uc_arbiter_if.slave (requests, grants, broadcast, status)
// Optional feature: define UC_DEDUP_EN to keep a per-variable assignment map
// that drops repeated literals and flags opposite-polarity repeats as conflicts.
module uc_arbiter
    import c_arbiter_pkg::*;
#(
    parameter int NUM_ENGINE      = 4,
    parameter int VARIABLE_LENGTH = DEF_VARIABLE_LENGTH,
    parameter int UC_DEPTH        = 16
) (
    input  logic         clock,
    input  logic         reset,
    uc_arbiter_if.slave  bus
);
    localparam int unsigned IDX_W  = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;
    localparam int unsigned VIDX_W = VARIABLE_LENGTH - 1;
    localparam int unsigned CNT_W  = $clog2(UC_DEPTH + 1);
    localparam logic [VIDX_W-1:0] NULL_IDX = VIDX_W'(NULL_VAR);

    uc_arb_state_e              state_q;
    uc_arb_state_e              next_state;
    logic [IDX_W-1:0]           rr_ptr_q;
    logic [IDX_W-1:0]           grant_idx;
    logic [IDX_W-1:0]           cand;
    logic                       grant_any;
    logic                       can_grant;
    logic [NUM_ENGINE-1:0]      grant_vec;
    logic [VARIABLE_LENGTH-1:0] grant_lit;
    logic [VIDX_W-1:0]          grant_var;
    logic                       lit_null;
    logic                       push;
    logic                       pop;
    logic                       dup_conflict;
    logic                       conflict_evt;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [VARIABLE_LENGTH-1:0] fifo_dout;
    logic [CNT_W-1:0]           fifo_count;
    logic [VARIABLE_LENGTH-1:0] chosen_q;
    logic                       conflict_q;

    // Full is judged on the pre-dequeue count; reset gating keeps grants low
    // while the asynchronous reset is held.
    assign can_grant = reset && !fifo_full && (state_q != CONFLICT) && !bus.clear_in;

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_ENGINE; k++) begin
            cand = IDX_W'((32'(rr_ptr_q) + k) % 32'(NUM_ENGINE));
            if (can_grant && !grant_any && bus.uc_valid_in[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        grant_vec = '0;
        if (grant_any) grant_vec[grant_idx] = 1'b1;
    end

    assign grant_lit = bus.uc_in[grant_idx];
    assign grant_var = grant_lit[VIDX_W-1:0];
    assign lit_null  = (grant_var == NULL_IDX);

`ifdef UC_DEDUP_EN
    logic [2**VIDX_W-1:0] assigned_q;
    logic [2**VIDX_W-1:0] polarity_q;
    logic                 map_hit;

    assign map_hit      = assigned_q[grant_var];
    assign push         = grant_any && !lit_null && !map_hit;
    assign dup_conflict = grant_any && !lit_null && map_hit &&
                          (polarity_q[grant_var] != grant_lit[VARIABLE_LENGTH-1]);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            assigned_q <= '0;
            polarity_q <= '0;
        end else if (bus.clear_in) begin
            assigned_q <= '0;
            polarity_q <= '0;
        end else if (push) begin
            assigned_q[grant_var] <= 1'b1;
            polarity_q[grant_var] <= grant_lit[VARIABLE_LENGTH-1];
        end
    end
`else
    assign push         = grant_any && !lit_null;
    assign dup_conflict = 1'b0;
`endif

    assign conflict_evt = (|bus.conflict_in) || dup_conflict;

    uc_fifo #(
        .DEPTH (UC_DEPTH),
        .WIDTH (VARIABLE_LENGTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (bus.clear_in),
        .push  (push),
        .pop   (pop),
        .din   (grant_lit),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= next_state;
    end

    // A conflict arriving in IDLE suppresses the pop so no entry is lost
    // into a broadcast that would never be strobed.
    always_comb begin
        next_state = state_q;
        pop        = 1'b0;
        if (bus.clear_in) begin
            next_state = IDLE;
        end else if (conflict_evt) begin
            next_state = CONFLICT;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        next_state = BCAST;
                    end
                end
                BCAST:    next_state = WAIT;
                WAIT:     if (bus.round_done_in) next_state = IDLE;
                CONFLICT: next_state = CONFLICT;
                default:  next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr_q   <= '0;
            conflict_q <= 1'b0;
            chosen_q   <= '0;
        end else begin
            if (bus.clear_in) begin
                rr_ptr_q   <= '0;
                conflict_q <= 1'b0;
            end else begin
                if (grant_any)
                    rr_ptr_q <= (grant_idx == IDX_W'(NUM_ENGINE - 1)) ? '0 : grant_idx + IDX_W'(1);
                if (conflict_evt)
                    conflict_q <= 1'b1;
            end
            if (pop) chosen_q <= fifo_dout;
        end
    end

    assign bus.uc_grant_out        = grant_vec;
    assign bus.chosen_uc_out       = chosen_q;
    assign bus.chosen_uc_valid_out = (state_q == BCAST);
    assign bus.conflict_out        = conflict_q;
    assign bus.idle_out            = (state_q == IDLE) && fifo_empty;
    assign bus.fifo_count_out      = fifo_count;

endmodule

// File: tb/tb_uc_arbiter.sv
// Self-checking bench for uc_arbiter: a scoreboard queue of expected
// broadcast literals is filled as requests are accepted and drained on each
// broadcast strobe; directed checks cover grants, latency, full FIFO,
// conflict, dedup (when UC_DEDUP_EN is defined) and asynchronous reset.
module tb_uc_arbiter;
    import c_arbiter_pkg::*;

    localparam int NE    = 4;
    localparam int VL    = 11;
    localparam int DEPTH = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    uc_arbiter_if #(.NUM_ENGINE(NE), .VARIABLE_LENGTH(VL), .UC_DEPTH(DEPTH)) bus ();

    uc_arbiter #(.NUM_ENGINE(NE), .VARIABLE_LENGTH(VL), .UC_DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    literal_t exp_q[$];
`ifdef UC_DEDUP_EN
    bit m_asg [int unsigned];
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard model of what an accepted literal should produce.
    task automatic model_accept(input literal_t lit);
        int unsigned v;
        v = 32'(lit[VL-2:0]);
        if (v == 0) return;
`ifdef UC_DEDUP_EN
        if (m_asg.exists(v)) return;
        m_asg[v] = 1'b1;
`endif
        exp_q.push_back(lit);
    endtask

    // Monitor: sampled mid-low-phase, well away from the rising edge.
    always @(negedge clock) begin
        #2;
        if (!reset || bus.clear_in) begin
            exp_q.delete();
`ifdef UC_DEDUP_EN
            m_asg.delete();
`endif
        end else begin
            if (bus.chosen_uc_valid_out) begin
                check("bcast_expected", 32'(exp_q.size() != 0), 32'(1));
                if (exp_q.size() != 0)
                    check("bcast_lit", 32'(bus.chosen_uc_out), 32'(exp_q.pop_front()));
            end
            for (int e = 0; e < NE; e++)
                if (bus.uc_grant_out[e]) model_accept(bus.uc_in[e]);
        end
    end

    task automatic offer(input int e, input literal_t lit, input string tag);
        @(negedge clock);
        bus.uc_valid_in[e] = 1'b1;
        bus.uc_in[e]       = lit;
        #1;
        check(tag, 32'(bus.uc_grant_out), 32'(1) << e);
    endtask

    task automatic wait_strobe(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            #1;
            if (bus.chosen_uc_valid_out) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'(1));
    endtask

    task automatic pulse_done();
        @(negedge clock);
        bus.round_done_in = 1'b1;
        @(negedge clock);
        bus.round_done_in = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clock);
        bus.clear_in    = 1'b1;
        bus.uc_valid_in = '0;
        @(negedge clock);
        bus.clear_in = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_grant"},    32'(bus.uc_grant_out),        32'(0));
        check({pfx, "_chosen"},   32'(bus.chosen_uc_out),       32'(0));
        check({pfx, "_valid"},    32'(bus.chosen_uc_valid_out), 32'(0));
        check({pfx, "_conflict"}, 32'(bus.conflict_out),        32'(0));
        check({pfx, "_count"},    32'(bus.fifo_count_out),      32'(0));
        check({pfx, "_idle"},     32'(bus.idle_out),            32'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        bus.uc_valid_in   = '0;
        bus.uc_in         = '0;
        bus.conflict_in   = '0;
        bus.round_done_in = 1'b0;
        bus.clear_in      = 1'b0;

        // Reset values
        #1 reset = 1'b0;
        #1 check_reset_outputs("rst");
        @(negedge clock);
        reset = 1'b1;

        // Single UC from engine 2: grant same cycle, broadcast two cycles later
        offer(2, 11'h5BB, "single_grant");
        @(negedge clock);
        bus.uc_valid_in = '0;
        #1;
        check("single_count1", 32'(bus.fifo_count_out), 32'(1));
        check("single_no_early", 32'(bus.chosen_uc_valid_out), 32'(0));
        @(negedge clock);
        #1;
        check("single_valid", 32'(bus.chosen_uc_valid_out), 32'(1));
        check("single_lit", 32'(bus.chosen_uc_out), 32'h5BB);
        check("single_count0", 32'(bus.fifo_count_out), 32'(0));
        pulse_done();
        #1 check("single_idle", 32'(bus.idle_out), 32'(1));

        // Round-robin over four requesters
        do_clear();
        @(negedge clock);
        bus.uc_valid_in = '1;
        for (int e = 0; e < NE; e++) bus.uc_in[e] = VL'(e + 1);
        for (int k = 0; k < NE; k++) begin
            if (k > 0) begin
                @(negedge clock);
                bus.uc_valid_in[k-1] = 1'b0;
            end
            #1;
            check($sformatf("rr_grant%0d", k), 32'(bus.uc_grant_out), 32'(1) << k);
            if (k == 2) check("rr_first_bcast", 32'(bus.chosen_uc_valid_out), 32'(1));
        end
        @(negedge clock);
        bus.uc_valid_in = '0;
        #1 check("rr_holdoff0", 32'(bus.chosen_uc_valid_out), 32'(0));
        @(negedge clock);
        #1 check("rr_holdoff1", 32'(bus.chosen_uc_valid_out), 32'(0));
        for (int b = 1; b < NE; b++) begin
            pulse_done();
            wait_strobe($sformatf("rr_bcast%0d", b));
        end
        pulse_done();

        // FIFO full: full blocks the grant even in the pop cycle
        do_clear();
        for (int k = 0; k <= DEPTH; k++)
            offer(0, VL'(16 + k), $sformatf("full_fill%0d", k));
        @(negedge clock);
        bus.uc_in[0] = 11'h040;
        #1;
        check("full_count", 32'(bus.fifo_count_out), 32'(DEPTH));
        check("full_block0", 32'(bus.uc_grant_out), 32'(0));
        @(negedge clock);
        #1 check("full_block1", 32'(bus.uc_grant_out), 32'(0));
        @(negedge clock);
        bus.round_done_in = 1'b1;
        #1 check("full_block_done", 32'(bus.uc_grant_out), 32'(0));
        @(negedge clock);
        bus.round_done_in = 1'b0;
        #1 check("full_block_popcycle", 32'(bus.uc_grant_out), 32'(0));
        @(negedge clock);
        #1;
        check("full_grant_after_pop", 32'(bus.uc_grant_out), 32'(1));
        check("full_count_after_pop", 32'(bus.fifo_count_out), 32'(DEPTH - 1));
        @(negedge clock);
        bus.uc_valid_in = '0;
        #1 check("full_refill", 32'(bus.fifo_count_out), 32'(DEPTH));

        // Conflict input with three entries queued
        do_clear();
        #1 check("cf_cleared", 32'(bus.fifo_count_out), 32'(0));
        for (int k = 0; k < 4; k++)
            offer(1, VL'(8'h50 + k), $sformatf("cf_fill%0d", k));
        @(negedge clock);
        bus.uc_valid_in = '0;
        bus.conflict_in = 4'b0010;
        #1 check("cf_count3", 32'(bus.fifo_count_out), 32'(3));
        @(negedge clock);
        bus.conflict_in    = '0;
        bus.uc_valid_in[3] = 1'b1;
        bus.uc_in[3]       = 11'h060;
        bus.round_done_in  = 1'b1;
        #1;
        check("cf_flag", 32'(bus.conflict_out), 32'(1));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("cf_no_grant%0d", i), 32'(bus.uc_grant_out), 32'(0));
            check($sformatf("cf_no_strobe%0d", i), 32'(bus.chosen_uc_valid_out), 32'(0));
            @(negedge clock);
            bus.round_done_in = 1'b0;
            #1;
        end
        check("cf_count_held", 32'(bus.fifo_count_out), 32'(3));
        @(negedge clock);
        bus.clear_in = 1'b1;
        #1 check("cf_clear_blocks", 32'(bus.uc_grant_out), 32'(0));
        @(negedge clock);
        bus.clear_in    = 1'b0;
        bus.uc_valid_in = '0;
        #1;
        check("cf_clr_count", 32'(bus.fifo_count_out), 32'(0));
        check("cf_clr_flag", 32'(bus.conflict_out), 32'(0));
        check("cf_clr_idle", 32'(bus.idle_out), 32'(1));

        // Repeated literal and opposite polarity
        offer(0, 11'h005, "dd_grant1");
        @(negedge clock);
        bus.uc_valid_in = '0;
        wait_strobe("dd_bcast1");
        offer(0, 11'h005, "dd_grant2");
        @(negedge clock);
        bus.uc_valid_in = '0;
`ifdef UC_DEDUP_EN
        #1 check("dd_dup_count", 32'(bus.fifo_count_out), 32'(0));
`else
        #1 check("dd_dup_count", 32'(bus.fifo_count_out), 32'(1));
`endif
        offer(0, 11'h405, "dd_grant3");
        @(negedge clock);
        bus.uc_valid_in = '0;
`ifdef UC_DEDUP_EN
        #1 check("dd_opp_conflict", 32'(bus.conflict_out), 32'(1));
`else
        #1;
        check("dd_opp_conflict", 32'(bus.conflict_out), 32'(0));
        check("dd_opp_count", 32'(bus.fifo_count_out), 32'(2));
`endif
        do_clear();

        // Null literal is accepted and dropped
        offer(0, 11'h400, "null_grant");
        @(negedge clock);
        bus.uc_valid_in = '0;
        #1 check("null_count", 32'(bus.fifo_count_out), 32'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1 check($sformatf("null_no_strobe%0d", i), 32'(bus.chosen_uc_valid_out), 32'(0));
        end
        check("null_idle", 32'(bus.idle_out), 32'(1));

        // Asynchronous reset mid-WAIT with five entries queued
        for (int k = 0; k < 6; k++)
            offer(2, VL'(8'h70 + k), $sformatf("ar_fill%0d", k));
        @(negedge clock);
        bus.uc_valid_in = '0;
        #1 check("ar_count5", 32'(bus.fifo_count_out), 32'(5));
        #2;
        reset              = 1'b0;
        bus.uc_valid_in[2] = 1'b1;
        bus.uc_in[2]       = 11'h077;
        #1 check_reset_outputs("ar");
        @(negedge clock);
        bus.uc_valid_in = '0;
        reset           = 1'b1;
        @(negedge clock);
        #1 check_reset_outputs("ar_post");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
